// File: rtl/coin_acceptor.sv
// coin_acceptor: classifies coins by sensor pulse width, reports a coin code and drives accept/return gates.
module coin_acceptor #(
    parameter int CNT_W    = 8,
    parameter int W5_MIN   = 10,
    parameter int W5_MAX   = 20,
    parameter int W10_MIN  = 30,
    parameter int W10_MAX  = 45,
    parameter int GATE_CYC = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sense,
    input  logic       J,
    input  logic       N,
    input  logic       R,
    output logic [1:0] coin,
    output logic       gate_accept,
    output logic       gate_return,
    output logic       busy,
    output logic       jam,
    output logic       proto_err
);
    typedef enum logic [1:0] {IDLE, MEASURE, EMIT, GATE} state_t;
    localparam int GC_W = $clog2(GATE_CYC + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    state_t state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic [GC_W-1:0] gcnt, gcnt_n;
    logic [1:0] coin_n, code;
    logic sense_q, ga_n, gr_n, busy_n, jam_n, pe_n, accept_ok, resp_ok;
    assign code = (cnt == CNT_MAX) ? 2'b10 :
                  (cnt >= CNT_W'(W5_MIN) && cnt <= CNT_W'(W5_MAX)) ? 2'b00 :
                  (cnt >= CNT_W'(W10_MIN) && cnt <= CNT_W'(W10_MAX)) ? 2'b01 : 2'b10;
    assign accept_ok = (J ^ N) & ~R;
    assign resp_ok = accept_ok | (R & ~J & ~N);
    always_comb begin
        state_n = state;
        cnt_n = cnt;
        gcnt_n = gcnt;
        coin_n = 2'b11;
        ga_n = gate_accept;
        gr_n = gate_return;
        jam_n = 1'b0;
        pe_n = proto_err;
        case (state)
            IDLE: if (sense && !sense_q) begin
                state_n = MEASURE;
                cnt_n = CNT_W'(1);
            end
            MEASURE: if (sense) begin
                cnt_n = (cnt == CNT_MAX) ? cnt : cnt + 1'b1;
                jam_n = (cnt == CNT_MAX);
            end else begin
                state_n = EMIT;
                coin_n = code;
            end
            EMIT: begin
                state_n = GATE;
                gcnt_n = '0;
                ga_n = accept_ok;
                gr_n = ~accept_ok;
                pe_n = proto_err | ~resp_ok;
            end
            GATE: if (gcnt == GC_W'(GATE_CYC - 1)) begin
                state_n = IDLE;
                ga_n = 1'b0;
                gr_n = 1'b0;
            end else begin
                gcnt_n = gcnt + 1'b1;
            end
            default: state_n = IDLE;
        endcase
        busy_n = (state_n != IDLE);
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt <= '0;
            gcnt <= '0;
            sense_q <= 1'b1;
            coin <= 2'b11;
            gate_accept <= 1'b0;
            gate_return <= 1'b0;
            busy <= 1'b0;
            jam <= 1'b0;
            proto_err <= 1'b0;
        end else begin
            state <= state_n;
            cnt <= cnt_n;
            gcnt <= gcnt_n;
            sense_q <= sense;
            coin <= coin_n;
            gate_accept <= ga_n;
            gate_return <= gr_n;
            busy <= busy_n;
            jam <= jam_n;
            proto_err <= pe_n;
        end
    end
endmodule

// File: tb/tb_coin_acceptor.sv
// tb_coin_acceptor: transaction-level reference model driving randomized and boundary coins.
module tb_coin_acceptor;
    logic clk = 1'b0, rst = 1'b1, sense = 1'b0, J = 1'b0, N = 1'b0, R = 1'b0;
    logic [1:0] coin;
    logic gate_accept, gate_return, busy, jam, proto_err;
    int n_chk = 0, n_fail = 0;
    bit pe_m = 1'b0;

    coin_acceptor dut (
        .clk(clk), .rst(rst), .sense(sense), .J(J), .N(N), .R(R),
        .coin(coin), .gate_accept(gate_accept), .gate_return(gate_return),
        .busy(busy), .jam(jam), .proto_err(proto_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] obs();
        return {25'd0, coin, gate_accept, gate_return, busy, jam, proto_err};
    endfunction

    function automatic logic [31:0] idle_vec();
        return {25'd0, 2'b11, 4'b0000, pe_m};
    endfunction

    // Coin value from pulse width: the counter saturates at 255, which is always bad.
    function automatic logic [1:0] classify(input int w);
        if (w >= 255) return 2'b10;
        if (w >= 10 && w <= 20) return 2'b00;
        if (w >= 30 && w <= 45) return 2'b01;
        return 2'b10;
    endfunction

    // resp = {J,N,R}; abort_at > 0 asserts rst at that edge; linger keeps the coin in the detector.
    task automatic coin_txn(input int w, input logic [2:0] resp, input int abort_at, input bit linger);
        logic [1:0] code;
        bit acc, bad;
        logic [31:0] e;
        code = classify(w);
        acc = (resp == 3'b100) || (resp == 3'b010);
        bad = !(acc || resp == 3'b001);
        for (int t = 1; t <= w + 19; t++) begin
            if (t <= w) sense = 1'b1;
            else if (linger) sense = (t > w + 1);
            else sense = (t >= w + 2 && t <= w + 16) ? 1'($urandom_range(0, 1)) : 1'b0;
            {J, N, R} = (t == w + 2) ? resp : 3'($urandom_range(0, 7));
            rst = (t == abort_at);
            step();
            if (t == abort_at) begin
                pe_m = 1'b0;
                check($sformatf("abort w=%0d", w), obs(), idle_vec());
                rst = 1'b0;
                for (int k = 0; k < 3; k++) begin
                    step();
                    check($sformatf("post_abort w=%0d k=%0d", w, k), obs(), idle_vec());
                end
                sense = 1'b0;
                step();
                check("abort_release", obs(), idle_vec());
                return;
            end
            if (t == w + 2) pe_m = pe_m | bad;
            e = {25'd0,
                 (t == w + 1) ? code : 2'b11,
                 acc && t >= w + 2 && t <= w + 17,
                 !acc && t >= w + 2 && t <= w + 17,
                 t <= w + 17,
                 t >= 256 && t <= w,
                 pe_m};
            check($sformatf("w=%0d resp=%0b t=%0d", w, resp, t), obs(), e);
        end
        if (linger) begin
            for (int k = 0; k < 3; k++) begin
                step();
                check($sformatf("linger k=%0d", k), obs(), idle_vec());
            end
            sense = 1'b0;
            step();
            check("linger_release", obs(), idle_vec());
        end
    endtask

    initial begin
        int bw[8] = '{9, 10, 20, 21, 29, 30, 45, 46};
        sense = 1'b1;
        step();
        step();
        check("reset", obs(), idle_vec());
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step();
            check("coin_at_reset", obs(), idle_vec());
        end
        sense = 1'b0;
        step();
        coin_txn(15, 3'b010, 0, 1'b0);
        coin_txn(40, 3'b100, 0, 1'b0);
        foreach (bw[i]) coin_txn(bw[i], 3'b001, 0, 1'b0);
        coin_txn(300, 3'b001, 0, 1'b0);
        coin_txn(12, 3'b000, 0, 1'b0);
        coin_txn(33, 3'b101, 0, 1'b0);
        coin_txn(15, 3'b010, 0, 1'b1);
        coin_txn(15, 3'b010, 5, 1'b0);
        coin_txn(15, 3'b010, 0, 1'b0);
        coin_txn(12, 3'b100, 18, 1'b0);
        for (int i = 0; i < 25; i++)
            coin_txn($urandom_range(1, 60), 3'($urandom_range(0, 7)), 0, 1'($urandom_range(0, 3) == 0));
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
